// File: rtl/receiver.sv
// Serial frame receiver: preamble hunt, SIGNAL field check, descrambled PSDU delivery.
// Output and Error are registered one edge after the sampled bit; there is no backpressure.
module receiver (
  input  logic Clock,
  input  logic Reset,
  input  logic Input,
  output logic Output,
  output logic Error
);

  typedef enum logic [1:0] {HUNT, SIGNAL, SERVICE, DATA} state_t;

  state_t      state_q, state_d;
  logic [5:0]  hcnt_q, hcnt_d;
  logic        prev_q, prev_d;
  logic [22:0] sig_q, sig_d;
  logic [4:0]  scnt_q, scnt_d;
  logic [11:0] len_q, len_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic [4:0]  m_q, m_d;
  logic [6:0]  scr_q, scr_d;
  logic        out_q, out_d;
  logic        err_q, err_d;

  logic [23:0] sig_w;
  logic        sig_ok;
  logic [15:0] n;
  logic        s_n;
  logic [15:0] psdu_last;
  logic [15:0] tail_min;

  assign sig_w  = {sig_q, Input};
  assign sig_ok = (sig_w[23:20] == 4'b1101) && !sig_w[19] && !(^sig_w[23:6]) &&
                  (sig_w[5:0] == 6'd0) && (sig_w[18:7] != 12'd0);

  // n is the 1-based index of the data bit being sampled on this edge.
  assign n         = dcnt_q + 16'd1;
  assign s_n       = (n <= 16'd7) ? Input : (scr_q[6] ^ scr_q[3]);
  assign psdu_last = {1'b0, len_q, 3'b000} + 16'd16;
  assign tail_min  = {1'b0, len_q, 3'b000} + 16'd22;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= HUNT;
      hcnt_q  <= 6'd0;
      prev_q  <= 1'b0;
      sig_q   <= 23'd0;
      scnt_q  <= 5'd0;
      len_q   <= 12'd0;
      dcnt_q  <= 16'd0;
      m_q     <= 5'd0;
      scr_q   <= 7'd0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      prev_q  <= prev_d;
      sig_q   <= sig_d;
      scnt_q  <= scnt_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      m_q     <= m_d;
      scr_q   <= scr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    prev_d  = prev_q;
    sig_d   = sig_q;
    scnt_d  = scnt_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    m_d     = m_q;
    scr_d   = scr_q;
    out_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      HUNT: begin
        prev_d = Input;
        if (hcnt_q == 6'd0) begin
          hcnt_d = 6'd1;
        end else if (Input != prev_q) begin
          hcnt_d = (hcnt_q >= 6'd32) ? hcnt_q : hcnt_q + 6'd1;
        end else if (hcnt_q < 6'd32) begin
          hcnt_d = 6'd1;
        end else begin
          // The repeated bit and its predecessor are SIGNAL bits 2 and 1.
          state_d = SIGNAL;
          sig_d   = {21'd0, prev_q, Input};
          scnt_d  = 5'd2;
          hcnt_d  = 6'd0;
        end
      end
      SIGNAL: begin
        sig_d  = sig_w[22:0];
        scnt_d = scnt_q + 5'd1;
        if (scnt_q == 5'd23) begin
          if (sig_ok) begin
            state_d = SERVICE;
            len_d   = sig_w[18:7];
            dcnt_d  = 16'd0;
            m_d     = 5'd0;
            scr_d   = 7'd0;
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
            hcnt_d  = 6'd0;
          end
        end
      end
      SERVICE, DATA: begin
        dcnt_d = n;
        scr_d  = {scr_q[5:0], s_n};
        m_d    = (m_q == 5'd23) ? 5'd0 : m_q + 5'd1;
        if (state_q == DATA && n <= psdu_last) out_d = Input ^ s_n;
        if (state_q == SERVICE && n == 16'd16) state_d = DATA;
        // Field ends on the first 24-bit boundary that covers SERVICE, PSDU and tail.
        if (m_q == 5'd23 && n >= tail_min) begin
          state_d = HUNT;
          hcnt_d  = 6'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign Output = out_q;
  assign Error  = err_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: streams frames, predicts Output/Error per sampled bit.
module tb_receiver;

  logic Clock = 1'b0;
  logic Reset;
  logic Input;
  logic Output;
  logic Error;

  receiver dut (
    .Clock (Clock),
    .Reset (Reset),
    .Input (Input),
    .Output(Output),
    .Error (Error)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  int ones_cnt = 0;

  bit stim_q[$];
  bit exp_o[$];
  bit exp_e[$];
  bit sb_o[$];
  bit sb_e[$];
  bit mon_o, mon_e;

  // Monitor: one expected (Output, Error) pair per sampled bit.
  always @(negedge Clock) begin
    if (sb_o.size() > 0) begin
      mon_o = sb_o.pop_front();
      mon_e = sb_e.pop_front();
      n_tests++;
      if (Output !== mon_o || Error !== mon_e) begin
        n_fail++;
        $display("FAIL out_err @%0t: Output=%b Error=%b, expected Output=%b Error=%b",
                 $time, Output, Error, mon_o, mon_e);
      end
      if (Output === 1'b1) ones_cnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) stim_q.push_back(v[k]);
  endtask

  // mode 0: random PSDU bits, 1: all ones, 2: all zeros.
  task automatic add_frame(input logic [3:0] rate, input logic [11:0] len, input logic pflip,
                           input logic [6:0] seed, input int mode);
    logic p;
    int   nd;
    bit   sc[];
    bit   pl;
    for (int k = 0; k < 48; k++) begin
      stim_q.push_back(1'b1);
      stim_q.push_back(1'b0);
    end
    p = (^{rate, 1'b0, len}) ^ pflip;
    push_bits({8'd0, rate, 1'b0, len, p, 6'd0}, 24);
    nd = 24 * ((8 * int'(len) + 22 + 23) / 24);
    sc = new[nd + 1];
    for (int n = 1; n <= nd; n++) begin
      if (n <= 7) sc[n] = seed[7 - n];
      else        sc[n] = sc[n - 7] ^ sc[n - 4];
      pl = 1'b0;
      if (n > 16 && n <= 16 + 8 * int'(len))
        pl = (mode == 0) ? bit'($urandom_range(0, 1)) : (mode == 1);
      stim_q.push_back(pl ^ sc[n]);
    end
  endtask

  // Reference: parses the whole stream as frames and predicts each cycle's outputs.
  task automatic run_model();
    int          N, i, cnt, err_idx, nd, L;
    logic [23:0] w;
    bit          sc[];
    bit          ok;
    N = stim_q.size();
    exp_o.delete();
    exp_e.delete();
    for (int k = 0; k < N; k++) exp_o.push_back(1'b0);
    i = 0; cnt = 0; err_idx = N;
    while (i < N) begin
      if (cnt >= 32 && stim_q[i] == stim_q[i - 1]) begin
        if (i + 22 >= N) break;
        w = '0;
        for (int k = 0; k < 24; k++) w = {w[22:0], stim_q[i - 1 + k]};
        L  = int'(w[18:7]);
        ok = (w[23:20] == 4'b1101) && !w[19] && ($countones(w[23:6]) % 2 == 0) &&
             (w[5:0] == 6'd0) && (L != 0);
        i  += 23;
        cnt = 0;
        if (!ok) begin
          if (i - 1 < err_idx) err_idx = i - 1;
        end else begin
          nd = 24 * ((8 * L + 22 + 23) / 24);
          sc = new[nd + 1];
          for (int n = 1; n <= nd; n++) begin
            if (i + n - 1 >= N) break;
            sc[n] = (n <= 7) ? stim_q[i + n - 1] : (sc[n - 7] ^ sc[n - 4]);
            if (n > 16 && n <= 16 + 8 * L) exp_o[i + n - 1] = stim_q[i + n - 1] ^ sc[n];
          end
          i += nd;
        end
      end else begin
        if (cnt == 0 || stim_q[i] == stim_q[i - 1]) cnt = 1;
        else cnt++;
        i++;
      end
    end
    for (int k = 0; k < N; k++) exp_e.push_back(k >= err_idx);
  endtask

  // Entered and left in the low clock phase so no unmodelled bit is sampled.
  task automatic drive_stream(input int upto);
    for (int i = 0; i < upto; i++) begin
      Input = stim_q[i];
      @(posedge Clock);
      sb_o.push_back(exp_o[i]);
      sb_e.push_back(exp_e[i]);
      @(negedge Clock);
    end
    #1;
    check("scoreboard_drained", sb_o.size(), 0);
  endtask

  task automatic do_reset();
    #1 Reset = 1'b1;
    #1;
    check("rst_output", Output, 0);
    check("rst_error", Error, 0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    #1;
  endtask

  task automatic new_stream();
    stim_q.delete();
    ones_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int cut;
    Reset = 1'b1;
    Input = 1'b0;
    @(negedge Clock);
    #1;

    // Nominal frame, all-ones PSDU, then a second frame to show return to HUNT.
    do_reset();
    new_stream();
    add_frame(4'b1101, 12'd16, 1'b0, 7'b1110111, 1);
    run_model();
    drive_stream(stim_q.size());
    check("psdu_ones_len16", ones_cnt, 128);
    check("no_error_good_frame", Error, 0);
    new_stream();
    add_frame(4'b1101, 12'd5, 1'b0, 7'($urandom_range(1, 127)), 0);
    run_model();
    drive_stream(stim_q.size());

    // Parity flipped: error, no output.
    do_reset();
    new_stream();
    add_frame(4'b1101, 12'd16, 1'b1, 7'b1110111, 1);
    run_model();
    drive_stream(stim_q.size());
    check("parity_no_output", ones_cnt, 0);
    check("parity_error", Error, 1);

    // Bad RATE, then a good frame still decodes with Error held.
    do_reset();
    new_stream();
    add_frame(4'b1111, 12'd16, 1'b0, 7'b1011001, 0);
    add_frame(4'b1101, 12'd4, 1'b0, 7'b0110101, 0);
    run_model();
    drive_stream(stim_q.size());
    check("rate_error_sticky", Error, 1);

    // Short alternation broken by a repeat, then a real preamble.
    do_reset();
    new_stream();
    for (int k = 0; k < 10; k++) begin
      stim_q.push_back(1'b1);
      stim_q.push_back(1'b0);
    end
    stim_q.push_back(1'b0);
    add_frame(4'b1101, 12'd7, 1'b0, 7'($urandom_range(1, 127)), 0);
    run_model();
    drive_stream(stim_q.size());
    check("short_preamble_no_error", Error, 0);

    // Reset during DATA while Output=1 and Error=1, then a valid frame.
    do_reset();
    new_stream();
    add_frame(4'b1101, 12'd16, 1'b1, 7'b1110111, 0);
    add_frame(4'b1101, 12'd16, 1'b0, 7'b0101110, 1);
    run_model();
    cut = -1;
    for (int k = 0; k < exp_o.size(); k++) if (cut < 0 && exp_o[k]) cut = k;
    check("cut_found", cut >= 0, 1);
    if (cut >= 0) drive_stream(cut + 1);
    do_reset();
    new_stream();
    add_frame(4'b1101, 12'd9, 1'b0, 7'($urandom_range(1, 127)), 0);
    run_model();
    drive_stream(stim_q.size());

    // Seed 1111111 with zero PSDU descrambles to zeros.
    do_reset();
    new_stream();
    add_frame(4'b1101, 12'd16, 1'b0, 7'b1111111, 2);
    run_model();
    drive_stream(stim_q.size());
    check("zero_psdu_ones", ones_cnt, 0);

    // LENGTH = 0 is rejected.
    do_reset();
    new_stream();
    add_frame(4'b1101, 12'd0, 1'b0, 7'b1000001, 0);
    run_model();
    drive_stream(stim_q.size());
    check("len0_error", Error, 1);

    // Randomized streams with junk prefixes and occasional bad frames.
    for (int t = 0; t < 6; t++) begin
      int junk;
      do_reset();
      new_stream();
      junk = $urandom_range(0, 30);
      for (int k = 0; k < junk; k++) stim_q.push_back(bit'($urandom_range(0, 1)));
      add_frame(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1101,
                12'($urandom_range(1, 24)), ($urandom_range(0, 3) == 0),
                7'($urandom_range(1, 127)), 0);
      add_frame(4'b1101, 12'($urandom_range(1, 24)), 1'b0, 7'($urandom_range(1, 127)), 0);
      run_model();
      drive_stream(stim_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
